// File: rtl/spi_frame_arbiter_pkg.sv
// Shared definitions for the SPI frame arbiter: controller state encoding,
// default frame geometry and the width of the per-frame length field.
package spi_frame_arbiter_pkg;

    localparam int MAX_LEN_DEF       = 4;
    localparam int START_TIMEOUT_DEF = 16;
    localparam int LEN_W             = 3;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_START,
        ST_WAIT_LOW,
        ST_WAIT_HIGH,
        ST_FINISH
    } state_t;

endpackage

// File: rtl/spi_rr_arbiter2.sv
// Two-way round-robin pick with a last-served flag; the flag only moves when
// a frame finishes, so the requester that just completed loses the next tie.
module spi_rr_arbiter2 (
    input  logic clk,
    input  logic reset,
    input  logic req0,
    input  logic req1,
    input  logic update,
    input  logic served,
    output logic any_req,
    output logic pick
);

    logic last_q;

    assign any_req = req0 | req1;
    assign pick    = (req0 & req1) ? ~last_q : req1;

    // Last-served starts at 1 so requester 0 wins the first tie.
    always_ff @(posedge clk) begin
        if (reset) begin
            last_q <= 1'b1;
        end else if (update) begin
            last_q <= served;
        end
    end

endmodule

// File: rtl/spi_frame_arbiter.sv
// Arbitrates two frame requesters onto one byte-wide spi_master, sending the
// latched frame MSB-byte first and handshaking each byte on spi_ss.
module spi_frame_arbiter
    import spi_frame_arbiter_pkg::*;
#(
    parameter int MAX_LEN       = MAX_LEN_DEF,
    parameter int START_TIMEOUT = START_TIMEOUT_DEF
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 req0,
    input  logic                 req1,
    input  logic [LEN_W-1:0]     len0,
    input  logic [LEN_W-1:0]     len1,
    input  logic [8*MAX_LEN-1:0] frame0,
    input  logic [8*MAX_LEN-1:0] frame1,
    output logic                 grant0,
    output logic                 grant1,
    output logic                 done0,
    output logic                 done1,
    output logic                 err0,
    output logic                 err1,
    output logic                 busy,
    output logic                 spi_start,
    output logic [7:0]           spi_data,
    input  logic                 spi_ss
);

    localparam int               CNT_W     = $clog2(START_TIMEOUT) + 1;
    localparam logic [LEN_W-1:0] MAX_LEN_L = LEN_W'(MAX_LEN);

    state_t               state_q, state_n;
    logic                 owner_q;
    logic [LEN_W-1:0]     len_q;
    logic [LEN_W-1:0]     idx_q;
    logic [CNT_W-1:0]     cnt_q;
    logic [7:0]           bytes_q [1<<LEN_W];

    logic                 any_req;
    logic                 pick;
    logic [LEN_W-1:0]     win_len;
    logic [LEN_W-1:0]     win_len_clamp;
    logic [8*MAX_LEN-1:0] win_frame;
    logic [LEN_W-1:0]     idx_inc;
    logic                 timed_out;
    logic                 grant_n, done_n, err_n, start_n, busy_n;

    spi_rr_arbiter2 u_arb (
        .clk     (clk),
        .reset   (reset),
        .req0    (req0),
        .req1    (req1),
        .update  (state_q == ST_FINISH),
        .served  (owner_q),
        .any_req (any_req),
        .pick    (pick)
    );

    assign win_len       = pick ? len1 : len0;
    assign win_len_clamp = (win_len > MAX_LEN_L) ? MAX_LEN_L : win_len;
    assign win_frame     = pick ? frame1 : frame0;
    assign idx_inc       = idx_q + LEN_W'(1);
    assign timed_out     = (cnt_q == CNT_W'(START_TIMEOUT - 1));

    always_comb begin
        state_n = state_q;
        grant_n = 1'b0;
        done_n  = 1'b0;
        err_n   = 1'b0;
        start_n = 1'b0;
        busy_n  = 1'b1;
        unique case (state_q)
            ST_IDLE: begin
                busy_n  = any_req;
                grant_n = any_req;
                if (any_req) begin
                    state_n = (win_len_clamp != '0) ? ST_START : ST_FINISH;
                end
            end
            ST_START: begin
                start_n = 1'b1;
                state_n = ST_WAIT_LOW;
            end
            ST_WAIT_LOW: begin
                // A falling select always wins over an expiring timeout.
                if (!spi_ss) begin
                    state_n = ST_WAIT_HIGH;
                end else if (timed_out) begin
                    err_n   = 1'b1;
                    state_n = ST_IDLE;
                end
            end
            ST_WAIT_HIGH: begin
                if (spi_ss) begin
                    state_n = (idx_inc < len_q) ? ST_START : ST_FINISH;
                end
            end
            ST_FINISH: begin
                done_n  = 1'b1;
                state_n = ST_IDLE;
            end
            default: state_n = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q   <= ST_IDLE;
            owner_q   <= 1'b0;
            len_q     <= '0;
            idx_q     <= '0;
            cnt_q     <= '0;
            grant0    <= 1'b0;
            grant1    <= 1'b0;
            done0     <= 1'b0;
            done1     <= 1'b0;
            err0      <= 1'b0;
            err1      <= 1'b0;
            busy      <= 1'b0;
            spi_start <= 1'b0;
            spi_data  <= 8'h00;
        end else begin
            state_q   <= state_n;
            grant0    <= grant_n & ~pick;
            grant1    <= grant_n & pick;
            done0     <= done_n & ~owner_q;
            done1     <= done_n & owner_q;
            err0      <= err_n & ~owner_q;
            err1      <= err_n & owner_q;
            busy      <= busy_n;
            spi_start <= start_n;
            if (grant_n) begin
                owner_q <= pick;
                len_q   <= win_len_clamp;
                idx_q   <= '0;
            end
            if (start_n) begin
                spi_data <= bytes_q[idx_q];
                cnt_q    <= '0;
            end
            if (state_q == ST_WAIT_LOW && spi_ss) begin
                cnt_q <= cnt_q + CNT_W'(1);
            end
            if (state_q == ST_WAIT_HIGH && spi_ss) begin
                idx_q <= idx_inc;
            end
        end
    end

    // Payload copy is pure data; it is only meaningful after a grant.
    always_ff @(posedge clk) begin
        if (grant_n) begin
            for (int i = 0; i < MAX_LEN; i++) begin
                bytes_q[i] <= win_frame[8*(MAX_LEN-1-i) +: 8];
            end
        end
    end

endmodule

// File: tb/tb_spi_frame_arbiter.sv
// Randomised and directed bench for spi_frame_arbiter against a frame-level
// reference model driven by the same spi_ss the bench's slave stub produces.
module tb_spi_frame_arbiter;
    import spi_frame_arbiter_pkg::*;

    localparam int MAX_LEN       = MAX_LEN_DEF;
    localparam int START_TIMEOUT = START_TIMEOUT_DEF;

    logic                 clk = 1'b0;
    logic                 reset = 1'b1;
    logic                 req0 = 1'b0, req1 = 1'b0;
    logic [LEN_W-1:0]     len0 = '0, len1 = '0;
    logic [8*MAX_LEN-1:0] frame0 = '0, frame1 = '0;
    logic                 grant0, grant1, done0, done1, err0, err1, busy, spi_start;
    logic [7:0]           spi_data;
    logic                 spi_ss;

    always #5 clk = ~clk;

    spi_frame_arbiter #(.MAX_LEN(MAX_LEN), .START_TIMEOUT(START_TIMEOUT)) dut (
        .clk(clk), .reset(reset), .req0(req0), .req1(req1), .len0(len0), .len1(len1),
        .frame0(frame0), .frame1(frame1), .grant0(grant0), .grant1(grant1),
        .done0(done0), .done1(done1), .err0(err0), .err1(err1), .busy(busy),
        .spi_start(spi_start), .spi_data(spi_data), .spi_ss(spi_ss)
    );

    int  n_checks = 0;
    int  n_pass = 0;
    bit  chk_en = 0;
    bit  ss_stuck = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    endtask

    // Reference model: expected outputs for the cycle following each edge
    logic [1:0] m_grant = '0, m_done = '0, m_err = '0;
    logic       m_busy = 0, m_start = 0, m_abort = 0, m_last = 1;
    logic [7:0] m_data = '0;

    task automatic step();
        @(posedge clk);
        m_grant = '0; m_done = '0; m_err = '0; m_start = 1'b0;
        m_abort = reset;
        if (reset) begin
            m_busy = 1'b0; m_data = 8'h00; m_last = 1'b1;
        end
    endtask

    task automatic run_frame();
        bit w;
        int n;
        int t;
        bit low;
        logic [8*MAX_LEN-1:0] f;
        logic [7:0] q[$];
        if (req0 && req1) w = ~m_last;
        else              w = req1;
        n = w ? int'(len1) : int'(len0);
        if (n > MAX_LEN) n = MAX_LEN;
        f = w ? frame1 : frame0;
        for (int i = 0; i < n; i++) q.push_back(f[8*(MAX_LEN-1-i) +: 8]);
        m_grant[w] = 1'b1;
        m_busy = 1'b1;
        while (q.size() > 0) begin
            step(); if (m_abort) return;
            m_start = 1'b1;
            m_data = q.pop_front();
            t = 0; low = 0;
            while (!low) begin
                step(); if (m_abort) return;
                if (!spi_ss) low = 1;
                else begin
                    t++;
                    if (t == START_TIMEOUT) begin m_err[w] = 1'b1; return; end
                end
            end
            do begin
                step(); if (m_abort) return;
            end while (!spi_ss);
        end
        step(); if (m_abort) return;
        m_done[w] = 1'b1;
        m_last = w;
    endtask

    initial begin : model
        forever begin
            step();
            if (!m_abort) begin
                m_busy = 1'b0;
                if (req0 || req1) run_frame();
            end
        end
    end

    always @(negedge clk) begin
        if (chk_en)
            chk("cycle_outputs",
                {grant1, grant0, done1, done0, err1, err0, busy, spi_start, spi_data},
                {m_grant, m_done, m_err, m_busy, m_start, m_data});
    end

    // Event logs for the directed literal expectations
    bit         grant_log[$];
    logic [7:0] byte_log[$];
    int n_done = 0, n_err = 0, n_start = 0, cyc = 0;
    int start_cyc = 0, err_cyc = 0, grant_cyc = 0, done_cyc = 0;

    always @(negedge clk) begin
        cyc++;
        if (grant0 === 1'b1) begin grant_log.push_back(1'b0); grant_cyc = cyc; end
        if (grant1 === 1'b1) begin grant_log.push_back(1'b1); grant_cyc = cyc; end
        if (spi_start === 1'b1) begin byte_log.push_back(spi_data); n_start++; start_cyc = cyc; end
        if (done0 === 1'b1 || done1 === 1'b1) begin n_done++; done_cyc = cyc; end
        if (err0 === 1'b1 || err1 === 1'b1) begin n_err++; err_cyc = cyc; end
    end

    task automatic clear_logs();
        grant_log.delete(); byte_log.delete();
        n_done = 0; n_err = 0; n_start = 0;
    endtask

    // Slave stub standing in for spi_master's chip-select behaviour
    initial begin : slave
        int d;
        spi_ss = 1'b1;
        forever begin
            @(posedge clk); #1;
            if (spi_start === 1'b1 && !ss_stuck && !reset) begin
                d = $urandom_range(0, 4);
                repeat (d) begin @(posedge clk); #1; end
                spi_ss = 1'b0;
                d = $urandom_range(1, 5);
                repeat (d) begin @(posedge clk); #1; end
                spi_ss = 1'b1;
            end
        end
    end

    function automatic bit pulse_sel(input int sel);
        case (sel)
            0:       return grant0 === 1'b1;
            1:       return grant1 === 1'b1;
            2:       return done0 === 1'b1;
            3:       return done1 === 1'b1;
            4:       return err0 === 1'b1;
            default: return spi_start === 1'b1;
        endcase
    endfunction

    task automatic wait_pulse(input int sel, input int limit, input string name);
        bit hit = 0;
        for (int k = 0; k < limit && !hit; k++) begin
            @(posedge clk); #1;
            hit = pulse_sel(sel);
        end
        chk(name, hit, 1'b1);
    endtask

    task automatic do_reset();
        req0 = 0; req1 = 0; reset = 1;
        repeat (3) @(posedge clk);
        #1 reset = 0;
        clear_logs();
    endtask

    initial begin : main
        int k;
        logic [8*MAX_LEN-1:0] f;
        @(posedge clk); #1 chk_en = 1;
        repeat (2) @(posedge clk);
        #1 reset = 0;
        @(negedge clk);
        chk("reset_state", {grant1, grant0, done1, done0, err1, err0, busy, spi_start, spi_data}, 16'h0000);

        // Test 1: three-byte frame, inputs scrambled after grant
        do_reset();
        len0 = 3; frame0 = 32'hFA03085C; req0 = 1;
        wait_pulse(0, 20, "t1_grant");
        req0 = 0; len0 = 6; frame0 = 32'h11223344;
        wait_pulse(2, 300, "t1_done");
        repeat (3) @(negedge clk);
        chk("t1_nbytes", byte_log.size(), 3);
        chk("t1_bytes", {byte_log[0], byte_log[1], byte_log[2]}, 24'hFA0308);
        chk("t1_grants", grant_log.size(), 1);
        chk("t1_dones", n_done, 1);
        chk("t1_busy", busy, 1'b0);

        // Test 2: simultaneous requests held high alternate
        do_reset();
        len0 = 1; len1 = 1; frame0 = 32'hAA000000; frame1 = 32'h55000000;
        req0 = 1; req1 = 1;
        k = 0;
        for (int c = 0; c < 400 && k < 4; c++) begin
            @(posedge clk); #1;
            if (done0 || done1) k++;
        end
        req0 = 0; req1 = 0;
        chk("t2_done_count", k, 4);
        repeat (3) @(negedge clk);
        chk("t2_ngrants", grant_log.size(), 4);
        chk("t2_order", {grant_log[0], grant_log[1], grant_log[2], grant_log[3]}, 4'b0101);
        chk("t2_bytes", {byte_log[0], byte_log[1], byte_log[2], byte_log[3]}, 32'hAA55AA55);

        // Test 3: zero-length frame
        do_reset();
        len1 = 0; req1 = 1;
        wait_pulse(1, 20, "t3_grant");
        req1 = 0;
        wait_pulse(3, 20, "t3_done");
        repeat (2) @(negedge clk);
        chk("t3_starts", n_start, 0);
        chk("t3_gap", done_cyc - grant_cyc, 1);
        chk("t3_owner", grant_log[0], 1'b1);

        // Test 4: length clamped to MAX_LEN
        do_reset();
        f = (8*MAX_LEN)'($urandom);
        len0 = 7; frame0 = f; req0 = 1;
        wait_pulse(0, 20, "t4_grant");
        req0 = 0;
        wait_pulse(2, 400, "t4_done");
        repeat (3) @(negedge clk);
        chk("t4_nbytes", n_start, 4);
        chk("t4_bytes", {byte_log[0], byte_log[1], byte_log[2], byte_log[3]}, f);

        // Test 5: select never falls
        do_reset();
        ss_stuck = 1;
        len0 = 2; frame0 = 32'h12345678; req0 = 1;
        wait_pulse(0, 20, "t5_grant");
        req0 = 0;
        wait_pulse(4, 60, "t5_err");
        repeat (3) @(negedge clk);
        chk("t5_errs", n_err, 1);
        chk("t5_dones", n_done, 0);
        chk("t5_starts", n_start, 1);
        chk("t5_err_delay", err_cyc - start_cyc, 16);
        chk("t5_busy", busy, 1'b0);
        ss_stuck = 0;

        // Test 6: reset during the second byte
        do_reset();
        len0 = 4; frame0 = 32'hC0FFEE11; req0 = 1;
        wait_pulse(0, 20, "t6_grant");
        req0 = 0;
        wait_pulse(5, 40, "t6_start1");
        wait_pulse(5, 40, "t6_start2");
        @(posedge clk); #1 reset = 1;
        @(posedge clk); @(negedge clk);
        chk("t6_reset_outputs", {grant1, grant0, done1, done0, err1, err0, busy, spi_start, spi_data}, 16'h0000);
        repeat (10) @(posedge clk);
        #1 reset = 0;
        repeat (3) @(negedge clk);
        chk("t6_no_done", n_done, 0);
        chk("t6_no_err", n_err, 0);
        chk("t6_no_start", n_start, 2);
        @(posedge clk); #1;
        len0 = 1; len1 = 1; req0 = 1; req1 = 1;
        k = 0;
        for (int c = 0; c < 20 && k == 0; c++) begin
            @(posedge clk); #1;
            if (grant0 || grant1) k = 1;
        end
        req0 = 0; req1 = 0;
        chk("t6_regrant", k, 1);
        repeat (60) @(posedge clk);
        chk("t6_tie_winner", grant_log[1], 1'b0);
        chk("t6_done_after", n_done, 1);

        // Randomised traffic, checked every cycle against the model
        for (int c = 0; c < 4000; c++) begin
            @(posedge clk); #1;
            if ($urandom_range(0, 9) == 0) req0 = ~req0;
            if ($urandom_range(0, 9) == 0) req1 = ~req1;
            if ($urandom_range(0, 5) == 0) begin
                len0 = LEN_W'($urandom_range(0, 7)); frame0 = (8*MAX_LEN)'($urandom);
            end
            if ($urandom_range(0, 5) == 0) begin
                len1 = LEN_W'($urandom_range(0, 7)); frame1 = (8*MAX_LEN)'($urandom);
            end
            if ($urandom_range(0, 299) == 0) ss_stuck = ~ss_stuck;
            reset = ($urandom_range(0, 499) == 0);
        end
        req0 = 0; req1 = 0; reset = 0; ss_stuck = 0;
        repeat (80) @(posedge clk);
        @(negedge clk);
        chk("final_idle_busy", busy, 1'b0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
